// File: rtl/expu_stream_ctrl.sv
// expu_stream_ctrl
// Valid/ready flow controller for an exponential-unit row pipeline of
// NUM_REGS registers. Tracks which registers hold live elements, enables only
// occupied stages, collapses bubbles under back-pressure and carries an
// end-of-vector tag alongside each element.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   clear_i            synchronous flush of all in-flight elements
//   in_valid_i/in_last_i/in_ready_o    upstream handshake + last tag
//   out_valid_o/out_last_o/out_ready_i downstream handshake + last tag
//   stage_en_o         row enable; bit i loads register i+1 from stage i
//   stage_clr_o        row clear (follows clear_i)
//   count_o, idle_o    elements in flight, nothing in flight
module expu_stream_ctrl #(
  parameter int unsigned  NUM_REGS  = 3,
  localparam int unsigned CNT_WIDTH = (NUM_REGS == 0) ? 1 : $clog2(NUM_REGS + 1),
  localparam int unsigned EN_WIDTH  = (NUM_REGS == 0) ? 1 : NUM_REGS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 in_valid_i,
  input  logic                 in_last_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  output logic                 out_last_o,
  input  logic                 out_ready_i,
  output logic [EN_WIDTH-1:0]  stage_en_o,
  output logic                 stage_clr_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 idle_o
);

  assign stage_clr_o = clear_i;

  if (NUM_REGS == 0) begin : g_passthru
    // No registers: the row is combinational, clock and reset are not needed.
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk_i, rst_ni};

    assign in_ready_o  = out_ready_i && !clear_i;
    assign out_valid_o = in_valid_i && !clear_i;
    assign out_last_o  = in_last_i;
    assign stage_en_o  = '0;
    assign count_o     = '0;
    assign idle_o      = 1'b1;
  end else begin : g_pipe
    logic [NUM_REGS:1]   v_q;
    logic [NUM_REGS:1]   t_q;
    // Index 0 is the input stage; index k is register k.
    logic [NUM_REGS:0]   v_in;
    logic [NUM_REGS:0]   t_in;
    logic [NUM_REGS+1:1] r;
    logic                chain;
    logic [CNT_WIDTH-1:0] cnt;

    // Ready chain is built through a scalar accumulator so each r bit is a
    // plain function of state, not of other r bits.
    always_comb begin
      v_in  = {v_q, in_valid_i};
      t_in  = {t_q, in_last_i};
      r     = '0;
      chain = out_ready_i;
      r[NUM_REGS+1] = out_ready_i;
      for (int unsigned k = NUM_REGS; k >= 1; k--) begin
        chain = !v_q[k] || chain;
        r[k]  = chain;
      end
    end

    always_comb begin
      stage_en_o = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        stage_en_o[i] = v_in[i] && r[i+1] && !clear_i;
      end
    end

    always_comb begin
      cnt = '0;
      for (int unsigned k = 1; k <= NUM_REGS; k++) begin
        cnt = cnt + CNT_WIDTH'(v_q[k]);
      end
    end

    // Tags are qualified by valid so empty stages never carry a stale last flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v_q <= '0;
        t_q <= '0;
      end else if (clear_i) begin
        v_q <= '0;
        t_q <= '0;
      end else begin
        for (int unsigned k = 1; k <= NUM_REGS; k++) begin
          if (r[k]) begin
            v_q[k] <= v_in[k-1];
            t_q[k] <= t_in[k-1] && v_in[k-1];
          end
        end
      end
    end

    assign in_ready_o  = r[1] && !clear_i;
    assign out_valid_o = v_in[NUM_REGS] && !clear_i;
    assign out_last_o  = t_in[NUM_REGS];
    assign count_o     = cnt;
    assign idle_o      = (cnt == '0);
  end

endmodule

// File: tb/tb_expu_stream_ctrl.sv
module tb_expu_stream_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       clear, in_valid, in_last, out_ready;
  logic       in_ready, out_valid, out_last, stage_clr, idle;
  logic [2:0] stage_en;
  logic [1:0] count;

  logic       z_clear, z_in_valid, z_in_last, z_out_ready;
  logic       z_in_ready, z_out_valid, z_out_last, z_stage_clr, z_idle;
  logic [0:0] z_stage_en;
  logic [0:0] z_count;

  int checks = 0;
  int errors = 0;

  expu_stream_ctrl #(.NUM_REGS(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_last_o(out_last), .out_ready_i(out_ready),
    .stage_en_o(stage_en), .stage_clr_o(stage_clr),
    .count_o(count), .idle_o(idle)
  );

  expu_stream_ctrl #(.NUM_REGS(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(z_clear),
    .in_valid_i(z_in_valid), .in_last_i(z_in_last), .in_ready_o(z_in_ready),
    .out_valid_o(z_out_valid), .out_last_o(z_out_last), .out_ready_i(z_out_ready),
    .stage_en_o(z_stage_en), .stage_clr_o(z_stage_clr),
    .count_o(z_count), .idle_o(z_idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic s3(input string tag, input logic ir, input logic ov,
                    input logic [2:0] en, input logic [1:0] cnt);
    chk({tag, ".in_ready"}, in_ready, ir);
    chk({tag, ".out_valid"}, out_valid, ov);
    chk({tag, ".stage_en"}, stage_en, en);
    chk({tag, ".count"}, count, cnt);
    chk({tag, ".idle"}, idle, cnt == 2'd0);
  endtask

  task automatic drive(input logic v, input logic l, input logic o, input logic c);
    in_valid = v; in_last = l; out_ready = o; clear = c;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, popped;
    logic acc;
    clear = 0; in_valid = 0; in_last = 0; out_ready = 0;
    z_clear = 0; z_in_valid = 0; z_in_last = 0; z_out_ready = 0;

    // Reset state
    #2;
    s3("rst", 1, 0, 3'b000, 0);
    chk("rst.out_last", out_last, 0);
    chk("rst.stage_clr", stage_clr, 0);
    #5 rst_n = 1;
    tick;

    // Full-throughput stream A,B,C,D; last tag on D
    drive(1, 0, 1, 0); s3("t1c0", 1, 0, 3'b001, 0); tick;
    drive(1, 0, 1, 0); s3("t1c1", 1, 0, 3'b011, 1); tick;
    drive(1, 0, 1, 0); s3("t1c2", 1, 0, 3'b111, 2); tick;
    drive(1, 1, 1, 0); s3("t1c3", 1, 1, 3'b111, 3); chk("t1c3.last", out_last, 0); tick;
    drive(0, 0, 1, 0); s3("t1c4", 1, 1, 3'b110, 3); chk("t1c4.last", out_last, 0); tick;
    s3("t1c5", 1, 1, 3'b100, 2); chk("t1c5.last", out_last, 0); tick;
    s3("t1c6", 1, 1, 3'b000, 1); chk("t1c6.last", out_last, 1); tick;
    s3("t1c7", 1, 0, 3'b000, 0); tick;

    // Back-pressure fill: exactly 3 accepted
    drive(1, 0, 0, 0); s3("t2c0", 1, 0, 3'b001, 0); tick;
    s3("t2c1", 1, 0, 3'b011, 1); tick;
    s3("t2c2", 1, 0, 3'b111, 2); tick;
    s3("t2c3", 0, 1, 3'b000, 3); tick;
    s3("t2c4", 0, 1, 3'b000, 3); tick;
    drive(0, 0, 1, 0); s3("t2c5", 1, 1, 3'b110, 3);
    tick; tick; tick;
    s3("t2c8", 1, 0, 3'b000, 0);

    // Bubble collapse under back-pressure
    drive(1, 0, 0, 0); s3("t3c0", 1, 0, 3'b001, 0); tick;
    drive(0, 0, 0, 0); s3("t3c1", 1, 0, 3'b010, 1); tick;
    s3("t3c2", 1, 0, 3'b100, 1); tick;
    drive(1, 1, 0, 0); s3("t3c3", 1, 1, 3'b001, 1); tick;
    drive(0, 0, 0, 0); s3("t3c4", 1, 1, 3'b010, 2); tick;
    s3("t3c5", 1, 1, 3'b000, 2); chk("t3c5.last", out_last, 0); tick;
    drive(0, 0, 1, 0); s3("t3c6", 1, 1, 3'b100, 2); chk("t3c6.last", out_last, 0); tick;
    s3("t3c7", 1, 1, 3'b000, 1); chk("t3c7.last", out_last, 1); tick;
    s3("t3c8", 1, 0, 3'b000, 0);

    // Last tag on 2nd of 4 elements with random back-pressure
    sent = 0; popped = 0;
    for (int cyc = 0; cyc < 80 && popped < 4; cyc++) begin
      drive(sent < 4, sent == 1, (cyc >= 40) ? 1'b1 : 1'($urandom_range(0, 1)), 0);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk("t4.last", out_last, popped == 1);
        popped++;
      end
      tick;
      if (acc) sent++;
    end
    chk("t4.popped", popped, 4);
    drive(0, 0, 1, 0);
    chk("t4.idle", idle, 1);

    // Clear with 2 in flight and in_valid high
    drive(1, 0, 1, 0); tick;
    tick;
    drive(0, 0, 1, 0); s3("t5c2", 1, 0, 3'b110, 2); tick;
    drive(1, 0, 1, 1);
    chk("t5c3.stage_clr", stage_clr, 1);
    chk("t5c3.in_ready", in_ready, 0);
    chk("t5c3.out_valid", out_valid, 0);
    chk("t5c3.stage_en", stage_en, 3'b000);
    chk("t5c3.count", count, 2);
    tick;
    drive(1, 0, 1, 0); s3("t5c4", 1, 0, 3'b001, 0); chk("t5c4.stage_clr", stage_clr, 0); tick;
    drive(0, 0, 1, 0); s3("t5c5", 1, 0, 3'b010, 1); tick;
    s3("t5c6", 1, 0, 3'b100, 1); tick;
    s3("t5c7", 1, 1, 3'b000, 1); tick;
    s3("t5c8", 1, 0, 3'b000, 0);

    // Asynchronous reset mid-stream
    drive(1, 0, 0, 0); tick; tick;
    chk("t6.count_pre", count, 2);
    rst_n = 0; #1;
    chk("t6.count", count, 0);
    chk("t6.idle", idle, 1);
    chk("t6.out_valid", out_valid, 0);
    #1 rst_n = 1;
    drive(0, 0, 1, 0); tick;

    // NUM_REGS = 0 pass-through
    for (int i = 0; i < 16; i++) begin
      logic [3:0] b;
      b = i[3:0];
      z_clear = b[3]; z_in_last = b[2]; z_in_valid = b[1]; z_out_ready = b[0];
      #1;
      chk("z.in_ready", z_in_ready, b[0] && !b[3]);
      chk("z.out_valid", z_out_valid, b[1] && !b[3]);
      chk("z.out_last", z_out_last, b[2]);
      chk("z.stage_clr", z_stage_clr, b[3]);
      chk("z.stage_en", z_stage_en, 0);
      chk("z.count", z_count, 0);
      chk("z.idle", z_idle, 1);
      tick;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/expu_stream_ctrl.md
# expu_stream_ctrl

Valid/ready flow controller that drives the per-stage `enable_i` and `clear_i` inputs of an exponential-unit row pipeline (`NUM_REGS` registers). It tracks which pipeline registers hold live data, advances only occupied stages, and collapses bubbles under downstream back-pressure. It also carries an end-of-vector tag alongside each element. One instance sits beside each row (or a group of lock-stepped rows) between the input streamer and the accumulation/normalisation stage. Register placement inside the row (before/after/around) does not affect this block: all `NUM_REGS` registers form one ordered chain.

## Interface
- `NUM_REGS`, default 3: number of pipeline registers in the controlled row; 0 is legal.
- `CNT_WIDTH`, localparam = `$clog2(NUM_REGS+1)`, minimum 1.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `clear_i`  in  1  synchronous flush of all in-flight elements.
- `in_valid_i`  in  1  upstream element present on the row's `op_i`.
- `in_last_i`  in  1  element is the last of its vector.
- `in_ready_o`  out  1  controller accepts the element this cycle.
- `out_valid_o`  out  1  row `res_o` holds a valid result.
- `out_last_o`  out  1  tag travelling with the output element.
- `out_ready_i`  in  1  downstream accepts the result.
- `stage_en_o`  out  `max(NUM_REGS,1)`  drives row `enable_i`; bit i loads register i+1 from stage i.
- `stage_clr_o`  out  1  drives row `clear_i`.
- `count_o`  out  `CNT_WIDTH`  elements currently in flight.
- `idle_o`  out  1  no element in flight.

## Operation
- State: `v[1..NUM_REGS]` (register k holds a live element) and `t[1..NUM_REGS]` (last tags).
- Stage 0 is the input: `v[0] = in_valid_i`, `t[0] = in_last_i`.
- Ready chain: `r[NUM_REGS+1] = out_ready_i`; `r[k] = !v[k] || r[k+1]` for k = 1..NUM_REGS.
- `in_ready_o = r[1] && !clear_i`. When `NUM_REGS = 0`: `in_ready_o = out_ready_i && !clear_i`.
- Advance: `stage_en_o[i] = v[i] && r[i+1] && !clear_i`.
  - Enable is data-gated: an empty stage never loads, so the row holds stale data without toggling.
- Valid update when `r[k]` is high and no clear: `v[k] <= v[k-1]`, `t[k] <= t[k-1]`. When `r[k]` is low, register k holds.
- Outputs:
  - `out_valid_o = v[NUM_REGS]`, `out_last_o = t[NUM_REGS]`.
  - When `NUM_REGS = 0`: `out_valid_o = in_valid_i && !clear_i`, `out_last_o = in_last_i`, `stage_en_o = 0`.
- Clear: `stage_clr_o = clear_i` (combinational). On the clear edge all `v` and `t` go to 0. No handshake completes in a clear cycle, in either direction: `out_valid_o` is forced low while `clear_i` is high.
- `count_o` = popcount of `v`; `idle_o = (count_o == 0)`. Both are combinational from state.
- The upstream contract is not checked: `in_last_i` is sampled only on an accepted transfer.

## Timing
- Reset values:
  - `v = 0`, `t = 0`.
  - `out_valid_o = 0`, `out_last_o = 0`, `count_o = 0`, `idle_o = 1`.
  - `stage_en_o = 0`; `stage_clr_o` follows `clear_i`.
  - `in_ready_o = 1` if `clear_i` is low.
- Latency: an element accepted at edge t is presented on `out_valid_o` after edge t+NUM_REGS−1, i.e. NUM_REGS cycles from acceptance to the output.
- Throughput: 1 element/cycle while `out_ready_i` is held high.
- Back-pressure: with `out_ready_i` low, empty stages still fill. The pipe absorbs up to NUM_REGS elements, then `in_ready_o` drops in the same cycle that the last empty register fills.
- `in_ready_o` depends combinationally on `out_ready_i` through the ready chain; the integration must avoid loops with upstream.
- Simultaneous output pop and input push on a full pipe: allowed. Count stays at NUM_REGS and all stages advance.
- Reset mid-stream: asynchronous. Everything returns to reset values immediately; in-flight data is discarded.
- Clear concurrent with `in_valid_i` / `out_ready_i`: clear wins and nothing transfers.

## Test plan
- NUM_REGS=3, `out_ready_i`=1, stream A,B,C,D on consecutive cycles -> outputs A..D on consecutive cycles starting 3 cycles after A is accepted; `stage_en_o` = 3'b001, 3'b011, 3'b111, 3'b111…; `count_o` peaks at 3.
- NUM_REGS=3, `out_ready_i`=0, continuous `in_valid_i` -> exactly 3 accepted; `in_ready_o`=0 from the cycle the 3rd enters; `count_o`=3; `stage_en_o`=0 while stalled.
- Bubble collapse: send A, then 2 idle cycles, then B, with `out_ready_i`=0 -> B enters register 2 directly behind A; `count_o`=2; on release, A and B emerge on consecutive cycles.
- Last tag: `in_last_i`=1 on the 2nd of 4 elements under random `out_ready_i` -> `out_last_o`=1 only with the 2nd output.
- `clear_i` pulse with 2 elements in flight and `in_valid_i`=1 -> `stage_clr_o`=1 that cycle; `in_ready_o`=0, `out_valid_o`=0; afterwards `count_o`=0, `idle_o`=1; the next element shows latency 3.
- NUM_REGS=0 -> `in_ready_o` mirrors `out_ready_i`; `out_valid_o` mirrors `in_valid_i`; `count_o`=0 at all times.
